vc_buffered_router_stub: RTL
============================

Name: vc_buffered_router_stub

Overview:
Parametrised successor to the single-cycle router pass-through stub. It keeps the same router-port signal set: data, valid and VC on the flit path; per-VC ACK, RDY and LCK for flow control. Each input port buffers flits in per-VC FIFOs. Each output port drains its paired input port with round-robin VC arbitration, credit-based flow control and downstream lock gating. It stands in for the real router in NoC mesh integration and verification before the full router is available.

Parameters:
NUM_PORTS, 5, number of router ports (N/E/S/W/local).
NUM_VC, 2, virtual channels per port; VC_W = max(1, $clog2(NUM_VC)).
DATA_W, 35, flit width.
FIFO_DEPTH, 4, flits per (port, VC) FIFO; power of two, at least 2.
CREDIT_INIT, 4, reset credit count per output VC; must be at least 1.
PORT_ROTATE, 0, output p sources input (p+PORT_ROTATE) mod NUM_PORTS.

Ports:
clk  in  1  clock
RST_  in  1  asynchronous active-low reset
IDATA  in  NUM_PORTS*DATA_W  input flits, port p at slice p
IVALID  in  NUM_PORTS  input flit valid
IVCH  in  NUM_PORTS*VC_W  input flit VC index
OACK  out  NUM_PORTS*NUM_VC  one-cycle pulse per accepted flit
ORDY  out  NUM_PORTS*NUM_VC  FIFO has space
OLCK  out  NUM_PORTS*NUM_VC  registered lock propagated upstream
ODATA  out  NUM_PORTS*DATA_W  output flits
OVALID  out  NUM_PORTS  output valid
OVCH  out  NUM_PORTS*VC_W  output VC index
IACK  in  NUM_PORTS*NUM_VC  downstream credit return, one pulse = one credit
ILCK  in  NUM_PORTS*NUM_VC  downstream VC locked
MY_XPOS  in  2  router X coordinate (unused unless stats feature)
MY_YPOS  in  2  router Y coordinate (unused unless stats feature)

Behaviour:
- Reset (asynchronous, RST_=0):
  - All FIFOs empty; credits = CREDIT_INIT; all round-robin pointers = VC0.
  - ODATA, OVALID, OVCH, OACK and OLCK all = 0; ORDY = all ones.
- Accept:
  - A flit is accepted on edge t when IVALID[p]=1, IVCH[p]<NUM_VC and count[p][v]<FIFO_DEPTH at the start of cycle t.
  - A pop in the same cycle does not free space for that push.
  - The accepted flit is written on edge t; OACK[p][v] is high for the cycle after edge t, then drops.
  - A flit with IVCH out of range, or to a full FIFO, is dropped with no OACK.
- ORDY[p][v] = (count < FIFO_DEPTH), decoded from the registered count; no combinational path from inputs.
- Output arbitration, output o, source input s:
  - VC v is eligible when FIFO[s][v] is non-empty, credit[o][v] > 0 and ILCK[o][v] = 0.
  - Round-robin starts from the VC after the last granted VC.
  - On a grant: pop FIFO, register ODATA/OVCH, OVALID=1 next cycle, decrement credit.
  - With no grant, OVALID=0 and ODATA/OVCH hold their previous values.
- Credits:
  - IACK[o][v] increments the credit; a simultaneous send and IACK leaves it unchanged.
  - Credit saturates at CREDIT_INIT; excess IACK is ignored.
- OLCK[s][v] = ILCK[o][v] delayed one cycle, where s is the source of o.
- Latency: IVALID at cycle t gives OVALID at cycle t+2 at the earliest (empty FIFO, credit available, unlocked).
- Throughput: one flit per cycle per output; order is preserved within a (port, VC).
- Wrap-around: FIFO pointers are log2(FIFO_DEPTH) bits plus a wrap bit; full = pointers equal with wrap bits differing.

Optional Feature:
Macro ROUTER_STUB_STATS_EN.
- Defined:
  - Adds output OVF_CNT (NUM_PORTS*8 bits): a per-input-port counter of dropped flits, saturating at 255 and cleared by reset.
  - Adds output NODE_ID (4 bits) = {MY_YPOS, MY_XPOS}, registered.
- Undefined: neither port exists, drops are silent, and MY_XPOS/MY_YPOS are unconnected.

Decomposition:
- Package router_stub_pkg holds:
  - default constants (DATA_W, NUM_VC, NUM_PORTS);
  - the vc_idx_t typedef;
  - a function for port-slice indexing;
  - the rotate-map function.
- Sub-module vc_fifo (parameters DATA_W, FIFO_DEPTH; push/pop/full/empty/count) is instantiated NUM_PORTS*NUM_VC times.

Test Plan:
- Single flit: reset; IDATA_0=35'h1_2345_6789, IVALID_0=1, IVCH_0=1 for one cycle. Required: OACK_0=2'b10 one cycle later; ODATA_0 equal to that flit with OVALID_0=1 and OVCH_0=1 at t+2.
- Fill and drop: hold ILCK_0=2'b01 and push 5 flits on port 0 VC0. Required: 4 OACKs, then ORDY_0[0]=0; the 5th flit is dropped (OVF_CNT=1 with the macro).
- Credit exhaustion: no IACK, 6 flits on VC0. Required: exactly 4 delivered, the rest stall; one IACK_0[0] pulse releases exactly one more.
- Round-robin: both VCs backlogged with 3 flits each. Required: OVCH alternates 0,1,0,1,0,1.
- Lock propagation: ILCK_2=2'b11. Required: OLCK_2=2'b11 one cycle later and no output from port 2; on release, flits resume in order.
- Mid-stream reset: assert RST_=0 during a burst. Required: outputs reset immediately; after release ORDY is all ones, credits are 4 and no stale flits emerge.

Source files
------------

// File: rtl/router_stub_pkg.sv
// Shared constants, types and index helpers for the buffered router stub.
// The optional stats build is selected with ROUTER_STUB_STATS_EN.
package router_stub_pkg;

  localparam int DEF_DATA_W    = 35;
  localparam int DEF_NUM_VC    = 2;
  localparam int DEF_NUM_PORTS = 5;
  localparam int DEF_VC_W      =
    (DEF_NUM_VC > 1) ? $clog2(DEF_NUM_VC) : 1;

  typedef logic [DEF_VC_W-1:0] vc_idx_t;

  function automatic int slice_lo(
    input int idx,
    input int width
  );
    return idx * width;
  endfunction

  // Input port that feeds output o.
  function automatic int rot_src(
    input int o,
    input int rot,
    input int n
  );
    return (o + rot) % n;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Per-(port, VC) flit FIFO with wrap-bit pointers.
// Push while full and pop while empty are ignored.
module vc_fifo #(
  parameter int DATA_W     = 35,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         pop,
  output logic [DATA_W-1:0]            rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FIFO_DEPTH):0]  count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) &&
                 (wptr[AW] != rptr[AW]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)
        wptr <= wptr + (AW+1)'(1);
      if (pop && !empty)
        rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vc_buffered_router_stub.sv
// Buffered router stub: per-VC input FIFOs, round-robin VC drain with
// credits and lock gating. ROUTER_STUB_STATS_EN adds OVF_CNT/NODE_ID.
module vc_buffered_router_stub
  import router_stub_pkg::*;
#(
  parameter int NUM_PORTS   = DEF_NUM_PORTS,
  parameter int NUM_VC      = DEF_NUM_VC,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int CREDIT_INIT = 4,
  parameter int PORT_ROTATE = 0,
  parameter int VC_W        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                        clk,
  input  logic                        RST_,
  input  logic [NUM_PORTS*DATA_W-1:0] IDATA,
  input  logic [NUM_PORTS-1:0]        IVALID,
  input  logic [NUM_PORTS*VC_W-1:0]   IVCH,
  output logic [NUM_PORTS*NUM_VC-1:0] OACK,
  output logic [NUM_PORTS*NUM_VC-1:0] ORDY,
  output logic [NUM_PORTS*NUM_VC-1:0] OLCK,
  output logic [NUM_PORTS*DATA_W-1:0] ODATA,
  output logic [NUM_PORTS-1:0]        OVALID,
  output logic [NUM_PORTS*VC_W-1:0]   OVCH,
  input  logic [NUM_PORTS*NUM_VC-1:0] IACK,
  input  logic [NUM_PORTS*NUM_VC-1:0] ILCK,
`ifdef ROUTER_STUB_STATS_EN
  output logic [NUM_PORTS*8-1:0]      OVF_CNT,
  output logic [3:0]                  NODE_ID,
`endif
  input  logic [1:0]                  MY_XPOS,
  input  logic [1:0]                  MY_YPOS
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CREDIT_INIT + 1);

  logic [NUM_PORTS-1:0][NUM_VC-1:0] push;
  logic [NUM_PORTS-1:0][NUM_VC-1:0] pop;
  logic [NUM_PORTS-1:0][NUM_VC-1:0] send;
  logic [NUM_PORTS-1:0]             gnt;
  logic [VC_W-1:0]                  gnt_vc  [NUM_PORTS];
  logic [VC_W-1:0]                  last_vc [NUM_PORTS];
  logic [CW-1:0]                    credit  [NUM_PORTS][NUM_VC];
  logic [DATA_W-1:0]                rdata   [NUM_PORTS][NUM_VC];
  logic                             full    [NUM_PORTS][NUM_VC];
  logic                             empty   [NUM_PORTS][NUM_VC];
  logic [AW:0]                      cnt     [NUM_PORTS][NUM_VC];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      vc_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst_n (RST_),
        .push  (push[p][v]),
        .wdata (IDATA[p*DATA_W +: DATA_W]),
        .pop   (pop[p][v]),
        .rdata (rdata[p][v]),
        .full  (full[p][v]),
        .empty (empty[p][v]),
        .count (cnt[p][v])
      );
    end
  end

  // Space is judged on the registered state only.
  always_comb begin
    push = '0;
    ORDY = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VC; v++) begin
        push[p][v] = IVALID[p] && !full[p][v] &&
          ({1'b0, IVCH[slice_lo(p, VC_W) +: VC_W]} ==
           (VC_W+1)'(v));
        ORDY[p*NUM_VC+v] = cnt[p][v] < (AW+1)'(FIFO_DEPTH);
      end
    end
  end

  always_comb begin
    int s;
    int c;
    s    = 0;
    c    = 0;
    pop  = '0;
    send = '0;
    gnt  = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      gnt_vc[o] = '0;
      s = rot_src(o, PORT_ROTATE, NUM_PORTS);
      for (int k = 1; k <= NUM_VC; k++) begin
        c = (int'(last_vc[o]) + k) % NUM_VC;
        if (!gnt[o] && !empty[s][c] &&
            credit[o][c] != '0 &&
            !ILCK[o*NUM_VC+c]) begin
          gnt[o]     = 1'b1;
          gnt_vc[o]  = VC_W'(c);
          pop[s][c]  = 1'b1;
          send[o][c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      ODATA  <= '0;
      OVALID <= '0;
      OVCH   <= '0;
      OACK   <= '0;
      OLCK   <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        last_vc[o] <= '0;
        for (int v = 0; v < NUM_VC; v++)
          credit[o][v] <= CW'(CREDIT_INIT);
      end
    end else begin
      OACK   <= push;
      OVALID <= gnt;
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (gnt[o]) begin
          ODATA[o*DATA_W +: DATA_W] <=
            rdata[rot_src(o, PORT_ROTATE, NUM_PORTS)][gnt_vc[o]];
          OVCH[o*VC_W +: VC_W] <= gnt_vc[o];
          last_vc[o]           <= gnt_vc[o];
        end
        OLCK[rot_src(o, PORT_ROTATE, NUM_PORTS)*NUM_VC +: NUM_VC]
          <= ILCK[o*NUM_VC +: NUM_VC];
        // Send and return together cancel; returns saturate.
        for (int v = 0; v < NUM_VC; v++) begin
          if (send[o][v] && !IACK[o*NUM_VC+v])
            credit[o][v] <= credit[o][v] - CW'(1);
          else if (!send[o][v] && IACK[o*NUM_VC+v] &&
                   credit[o][v] < CW'(CREDIT_INIT))
            credit[o][v] <= credit[o][v] + CW'(1);
        end
      end
    end
  end

`ifdef ROUTER_STUB_STATS_EN
  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      OVF_CNT <= '0;
      NODE_ID <= '0;
    end else begin
      NODE_ID <= {MY_YPOS, MY_XPOS};
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (IVALID[p] && !(|push[p]) &&
            OVF_CNT[p*8 +: 8] != 8'hff)
          OVF_CNT[p*8 +: 8] <= OVF_CNT[p*8 +: 8] + 8'd1;
      end
    end
  end
`else
  logic unused_pos;
  assign unused_pos = ^{MY_XPOS, MY_YPOS};
`endif

endmodule
